ir_theta_tracker: RTL and testbench
===================================

Name: ir_theta_tracker

Overview:
Converts the raw IR index-mark input from the rotor into a rotational angle index (theta) plus a measured revolution period, for consumption by frame_manager.
- Measures clock cycles between accepted index edges.
- Divides each revolution into ROTATIONAL_RES equal slices, with remainder cycles distributed so that slice durations sum exactly to the period.
- Advances theta once per slice.
- Sits directly upstream of frame_manager and supplies its theta / period / period_ready inputs.

Parameters:
ROTATIONAL_RES, 256, slices per revolution; power of two, >= 2
PERIOD_WIDTH, 24, width of the period counter and period output
MIN_PERIOD, 12000, edges arriving fewer than this many cycles after the last accepted edge are ignored; must be >= ROTATIONAL_RES

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
ir_tripped  input  1  asynchronous IR sensor level; rising edge = index mark
theta  output  $clog2(ROTATIONAL_RES)  current slice index
theta_step  output  1  one-cycle pulse whenever theta changes value or is re-zeroed by an edge
theta_valid  output  1  high while locked
period  output  PERIOD_WIDTH  last measured revolution length in cycles
period_ready  output  1  one-cycle pulse when period updates
locked  output  1  lock status

Behaviour:
Reset and latency
- rst_in=0 sampled at a clk_in edge clears all state on that edge.
- Reset values: theta=0, theta_step=0, theta_valid=0, period=0, period_ready=0, locked=0.
- Synchronizer is cleared to 0. An ir_tripped level already high when reset releases does not count as an edge.
- ir_tripped passes through a 2-FF synchronizer, then a rising-edge detect register.
- An edge first sampled high at clock N is detected at N+2. Its effects (theta=0, period_ready, theta_step) are visible at N+3.

Edge acceptance and period measurement
- gap_cnt increments every cycle, saturating at all-ones, and clears to 0 on each accepted edge.
- A detected edge is accepted if state is UNLOCKED, or if gap_cnt+1 >= MIN_PERIOD. Otherwise it is ignored with no output change.
- period = gap_cnt+1 at acceptance, i.e. the cycle distance between accepted edges.

State machine
- UNLOCKED -> ARMED on an accepted edge. gap_cnt cleared; outputs unchanged.
- ARMED -> LOCKED on the next accepted edge: period latched, period_ready pulses, locked=1, theta_valid=1, theta=0, slice timing starts.
- LOCKED -> LOCKED on an accepted edge: period updated, period_ready pulses, theta=0, theta_step pulses, slice accumulator cleared.
- ARMED or LOCKED -> UNLOCKED when gap_cnt saturates: locked=0, theta_valid=0, theta=0, period retained.

Slice timing (LOCKED)
- base = period >> log2(ROTATIONAL_RES).
- rem = period mod ROTATIONAL_RES.
- At each slice start, acc (log2(ROTATIONAL_RES) bits) += rem. On carry-out, the slice lasts base+1 cycles; otherwise it lasts base cycles.
- At slice end, theta increments and theta_step pulses.
- theta never wraps on its own. On reaching ROTATIONAL_RES-1 it holds until the next accepted edge (covers the rotor slowing down).
- If the next edge arrives early (rotor speeding up), theta jumps to 0 regardless of its current value.

Simultaneous events
- Accepted edge in the same cycle as a slice end: the edge wins.
- Accepted edge in the same cycle as gap_cnt saturation: the edge wins and the state stays LOCKED.

Optional Feature:
THETA_PERIOD_AVG_EN
- Defined: on a LOCKED->LOCKED edge, the effective period = (previous period + measured)/2, truncated. This value drives both the period output and slice timing. The ARMED->LOCKED transition uses the raw measurement.
- Undefined: the raw measurement is used every time.

Test Plan:
Bench parameters: ROTATIONAL_RES=8, MIN_PERIOD=16, PERIOD_WIDTH=12.
1. Hold rst_in=0 for 4 cycles with ir_tripped toggling -> all outputs 0, no pulses.
2. Rising edges every 80 cycles -> after 2nd edge: period=80, one period_ready pulse, locked=1. theta steps 0..7 every 10 cycles, then returns to 0 at the 3rd edge, 3 cycles after the edge sample.
3. Edge period 83 -> slice lengths 10,10,11,10,10,11,10,11, summing to 83. theta_step count per revolution = 8.
4. Locked at 80, inject extra edge 5 cycles after an accepted edge -> ignored: no period_ready, theta sequence unchanged.
5. Locked at 80, next gap 100 -> theta holds 7 from cycle 70 to the edge, then theta=0, period=100, period_ready pulse.
6. Locked, then no edges -> when gap_cnt reaches 4095: locked=0, theta_valid=0, theta=0, period still 80. Also: edge and saturation in the same cycle -> stays locked.

Source files
------------

// File: rtl/ir_theta_tracker.sv
// ir_theta_tracker: IR index marks -> revolution period and slice index theta.
// Define THETA_PERIOD_AVG_EN to average each locked period with the previous one.
module ir_theta_tracker #(
    parameter int ROTATIONAL_RES = 256,
    parameter int PERIOD_WIDTH   = 24,
    parameter int MIN_PERIOD     = 12000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] theta,
    output logic                              theta_step,
    output logic                              theta_valid,
    output logic [PERIOD_WIDTH-1:0]           period,
    output logic                              period_ready,
    output logic                              locked
);
    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam logic [PERIOD_WIDTH:0]   MIN_P = (PERIOD_WIDTH+1)'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE   = 1;
    localparam logic [TW-1:0]           TMAX  = '1;

    typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} state_t;
    state_t state, state_n;

    logic                    s1, s2, s3, edge_q;
    logic [1:0]              fill;
    logic [PERIOD_WIDTH-1:0] gap_cnt, left, meas, p_n;
    logic [PERIOD_WIDTH:0]   gap_inc;
    logic [TW-1:0]           acc, theta_n;
    logic [TW:0]             acc_sum;
    logic                    sat, accept, relock, slice_end;

    assign gap_inc     = {1'b0, gap_cnt} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
    assign sat         = &gap_cnt;
    assign meas        = sat ? gap_cnt : gap_inc[PERIOD_WIDTH-1:0];
    assign accept      = edge_q && (state == UNLOCKED || gap_inc >= MIN_P);
    assign relock      = accept && state == LOCKED;
    assign acc_sum     = {1'b0, acc} + {1'b0, period[TW-1:0]};
    assign slice_end   = state == LOCKED && !accept && !sat && left == '0 && theta != TMAX;
    assign theta_n     = (accept || sat || state != LOCKED) ? '0 :
                         slice_end ? theta + TW'(1) : theta;
    assign locked      = state == LOCKED;
    assign theta_valid = state == LOCKED;

`ifdef THETA_PERIOD_AVG_EN
    logic [PERIOD_WIDTH:0] p_sum;
    assign p_sum = {1'b0, period} + {1'b0, meas};
    assign p_n   = relock ? p_sum[PERIOD_WIDTH:1] : meas;
`else
    assign p_n   = meas;
`endif

    always_comb begin
        state_n = state;
        if (accept)
            state_n = (state == UNLOCKED) ? ARMED : LOCKED;
        else if (sat && state != UNLOCKED)
            state_n = UNLOCKED;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= UNLOCKED;
        else
            state <= state_n;
    end

    // fill gates edge detection until the synchronizer holds real samples,
    // so a level already high at reset release is not taken as an edge
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            edge_q       <= 1'b0;
            fill         <= '0;
            gap_cnt      <= '0;
            left         <= '0;
            acc          <= '0;
            theta        <= '0;
            theta_step   <= 1'b0;
            period       <= '0;
            period_ready <= 1'b0;
        end else begin
            s1           <= ir_tripped;
            s2           <= s1;
            s3           <= s2;
            fill         <= fill + {1'b0, ~&fill};
            edge_q       <= s2 && !s3 && &fill;
            gap_cnt      <= accept ? '0 : meas;
            theta        <= theta_n;
            theta_step   <= relock || theta_n != theta;
            period_ready <= accept && state != UNLOCKED;
            if (accept && state != UNLOCKED) begin
                period <= p_n;
                acc    <= p_n[TW-1:0];
                left   <= (p_n >> TW) - ONE;
            end else if (slice_end) begin
                acc    <= acc_sum[TW-1:0];
                left   <= (period >> TW) + {{(PERIOD_WIDTH-1){1'b0}}, acc_sum[TW]} - ONE;
            end else if (left != '0) begin
                left   <= left - ONE;
            end
        end
    end
endmodule

// File: tb/tb_ir_theta_tracker.sv
// tb_ir_theta_tracker: directed checks of ir_theta_tracker (RES=8, MIN=16, WIDTH=12).
module tb_ir_theta_tracker;
    logic        clk_in, rst_in, ir_tripped;
    logic [2:0]  theta;
    logic        theta_step, theta_valid, period_ready, locked;
    logic [11:0] period;

    int n_err = 0, n_chk = 0, n_st, n_rd, any;
    int th[0:4200], st[0:4200], rd[0:4200], lk[0:4200], vl[0:4200], pr[0:4200];

    ir_theta_tracker #(.ROTATIONAL_RES(8), .PERIOD_WIDTH(12), .MIN_PERIOD(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ir_tripped(ir_tripped),
        .theta(theta), .theta_step(theta_step), .theta_valid(theta_valid),
        .period(period), .period_ready(period_ready), .locked(locked)
    );

    initial clk_in = 0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // theta d cycles after the re-zero, for a revolution of p cycles
    function automatic int exp_th(input int p, input int d);
        int base, rem, acc, s, e;
        base = p / 8;
        rem  = p % 8;
        acc  = 0;
        s    = 0;
        for (int t = 0; t < 7; t++) begin
            acc += rem;
            e = s + base + (acc >= 8 ? 1 : 0);
            acc %= 8;
            if (d < e) return t;
            s = e;
        end
        return 7;
    endfunction

    // one index mark, then g cycles to the next; k=4 is the first cycle showing this mark
    task automatic rev(input int g, input int p, input bit extra);
        n_st = 0;
        n_rd = 0;
        ir_tripped = 1;
        for (int k = 1; k <= g; k++) begin
            @(negedge clk_in);
            th[k] = int'(theta);
            st[k] = int'(theta_step);
            rd[k] = int'(period_ready);
            lk[k] = int'(locked);
            vl[k] = int'(theta_valid);
            pr[k] = int'(period);
            if (k >= 4) begin
                n_st += st[k];
                n_rd += rd[k];
            end
            if (k == 3) ir_tripped = 0;
            if (extra && k == 5) ir_tripped = 1;
            if (extra && k == 7) ir_tripped = 0;
        end
        if (p > 0)
            for (int k = 4; k <= g; k++)
                chk($sformatf("theta_p%0d_k%0d", p, k), th[k], exp_th(p, k - 4));
    endtask

    initial begin
        rst_in = 0;
        ir_tripped = 0;
        any = 0;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            ir_tripped = ~ir_tripped;
            @(negedge clk_in);
            any += int'(theta_step) + int'(period_ready) + int'(locked) + int'(theta_valid);
        end
        chk("rst_pulses", any, 0);
        chk("rst_theta", int'(theta), 0);
        chk("rst_step", int'(theta_step), 0);
        chk("rst_valid", int'(theta_valid), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_ready", int'(period_ready), 0);
        chk("rst_locked", int'(locked), 0);
        ir_tripped = 0;
        rst_in = 1;
        repeat (6) @(negedge clk_in);

        rev(80, 0, 0);
        chk("armed_ready", n_rd, 0);
        chk("armed_locked", lk[80], 0);

        rev(80, 80, 0);
        chk("lock_ready", rd[4], 1);
        chk("lock_ready_cnt", n_rd, 1);
        chk("lock_period", pr[4], 80);
        chk("lock_locked", lk[4], 1);
        chk("lock_valid", vl[4], 1);

        rev(80, 80, 0);
        chk("rezero_pre", th[3], 7);
        chk("rezero_theta", th[4], 0);
        chk("rezero_step", st[4], 1);
        chk("rezero_ready", rd[4], 1);
        chk("steps80", n_st, 8);

        rev(83, 80, 0);
        rev(83, 83, 0);
        chk("period83", pr[4], 83);
        chk("steps83", n_st, 8);

        rev(80, 83, 0);
        rev(100, 80, 1);
        chk("extra_ready_cnt", n_rd, 1);
        chk("hold_start", th[74], 7);
        chk("hold_before", th[73], 6);

        rev(80, 100, 0);
        chk("slow_pre", th[3], 7);
        chk("slow_theta", th[4], 0);
        chk("slow_period", pr[4], 100);
        chk("slow_ready", rd[4], 1);

        rev(4096, 80, 0);
        chk("sat_prev_period", pr[4], 80);

        rev(80, 0, 0);
        chk("coinc_locked4", lk[4], 1);
        chk("coinc_locked5", lk[5], 1);
        chk("coinc_ready", rd[4], 1);
        chk("coinc_theta", th[4], 0);

        rev(4105, 0, 0);
        chk("unlk_period_in", pr[4], 80);
        chk("unlk_pre_locked", lk[4099], 1);
        chk("unlk_pre_theta", th[4099], 7);
        chk("unlk_locked", lk[4100], 0);
        chk("unlk_valid", vl[4100], 0);
        chk("unlk_theta", th[4100], 0);
        chk("unlk_period", pr[4100], 80);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
